// File: rtl/aux_bin2bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encodings,
// the overflow display nibble and a counter-width helper.
package aux_bin2bcd_pkg;

    typedef enum logic [1:0] {
        AUX_B2B_IDLE   = 2'd0,
        AUX_B2B_CONV   = 2'd1,
        AUX_B2B_FINISH = 2'd2
    } b2b_state_e;

    localparam logic [3:0] AUX_B2B_OVF_NIBBLE = 4'hE;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aux_bin2bcd_if.sv
// Request/result bundle between a producer and the binary-to-BCD converter.
interface aux_bin2bcd_if #(
    parameter int InBits = 27,
    parameter int Digits = 8
);
    logic                start;
    logic [InBits-1:0]   bin;
    logic                busy;
    logic                done;
    logic [4*Digits-1:0] bcd;
    logic                ovf;

    modport master (output start, bin, input busy, done, bcd, ovf);
    modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/aux_bcd_adj3.sv
// Combinational double-dabble digit corrector: digits of 5 or more get +3.
module aux_bcd_adj3 (
    input  logic [3:0] raw,
    output logic [3:0] adj
);
    assign adj = (raw >= 4'd5) ? raw + 4'd3 : raw;
endmodule

// File: rtl/aux_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Results are held in output registers that only change on the finishing edge.
module aux_bin2bcd
    import aux_bin2bcd_pkg::*;
#(
    parameter int         InBits    = 27,
    parameter int         Digits    = 8,
    parameter logic [3:0] OvfNibble = AUX_B2B_OVF_NIBBLE
) (
    input  logic         clk,
    input  logic         rst_n,
    aux_bin2bcd_if.slave io
);
    localparam int              CntW    = cnt_width(InBits);
    localparam int              BcdW    = 4 * Digits;
    localparam logic [CntW-1:0] LastCnt = CntW'(InBits - 1);

    b2b_state_e        state_reg, state_next;
    logic [InBits-1:0] shift_reg;
    logic [BcdW-1:0]   scratch_reg;
    logic [BcdW-1:0]   scratch_adj;
    logic              sticky_reg;
    logic [CntW-1:0]   cnt_reg;
    logic [BcdW-1:0]   bcd_reg;
    logic              ovf_reg;
    logic              done_reg;

    // Per-digit correction; digits never carry into each other.
    generate
        for (genvar gi = 0; gi < Digits; gi++) begin : g_adj
            aux_bcd_adj3 u_adj (
                .raw (scratch_reg[4*gi +: 4]),
                .adj (scratch_adj[4*gi +: 4])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            AUX_B2B_IDLE:   if (io.start) state_next = AUX_B2B_CONV;
            AUX_B2B_CONV:   if (cnt_reg == LastCnt) state_next = AUX_B2B_FINISH;
            AUX_B2B_FINISH: state_next = AUX_B2B_IDLE;
            default:        state_next = AUX_B2B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= AUX_B2B_IDLE;
            shift_reg   <= '0;
            scratch_reg <= '0;
            sticky_reg  <= 1'b0;
            cnt_reg     <= '0;
            bcd_reg     <= '0;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                AUX_B2B_IDLE: begin
                    if (io.start) begin
                        shift_reg   <= io.bin;
                        scratch_reg <= '0;
                        sticky_reg  <= 1'b0;
                        cnt_reg     <= '0;
                    end
                end
                AUX_B2B_CONV: begin
                    // Whatever falls off the top digit means the value exceeds the display.
                    scratch_reg <= {scratch_adj[BcdW-2:0], shift_reg[InBits-1]};
                    shift_reg   <= shift_reg << 1;
                    sticky_reg  <= sticky_reg | scratch_adj[BcdW-1];
                    cnt_reg     <= cnt_reg + CntW'(1);
                end
                AUX_B2B_FINISH: begin
                    ovf_reg  <= sticky_reg;
                    bcd_reg  <= sticky_reg ? {Digits{OvfNibble}} : scratch_reg;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io.busy = (state_reg != AUX_B2B_IDLE);
    assign io.done = done_reg;
    assign io.bcd  = bcd_reg;
    assign io.ovf  = ovf_reg;

endmodule

// File: doc/aux_bin2bcd.md
Name: aux_bin2bcd

Overview:
- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one bit per clock.
- Sits directly upstream of the 8-digit seven-segment display driver and feeds its 32-bit data input.
- Lets counters and datapath values be shown in decimal instead of hex.
- Holds its last result stable between conversions, so the display never shows partial values.

Parameters:
- InBits, 27, width of the binary input; 1..32.
- Digits, 8, number of BCD digits produced; the output is 4*Digits bits.
- OvfNibble, 4'hE, nibble replicated into every digit on overflow; shows "EEEEEEEE".

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request conversion; sampled only in IDLE.
- bin  in  InBits  binary value; captured on the clock edge where start is accepted.
- busy  out  1  high while a conversion is in progress (state != IDLE).
- done  out  1  one-cycle pulse when bcd/ovf have just been updated.
- bcd  out  4*Digits  registered result; digit k is bcd[4k+3:4k], digit 0 is least significant.
- ovf  out  1  registered; 1 when the last converted value was >= 10^Digits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, shift/count registers cleared.
  - Outputs: bcd=0, ovf=0, done=0, busy=0.
  - Reset mid-conversion abandons the conversion; no done pulse follows.
- States: IDLE, CONV, FINISH.
- IDLE:
  - done deasserts at the next edge unless it was just set.
  - On an edge with start=1: bin goes to the shift register, BCD scratch=0, sticky overflow scratch=0, bit counter=0, next state CONV.
  - start=0 keeps the state in IDLE.
- CONV, on each edge:
  - Every scratch digit >= 5 gets +3 (4-bit result).
  - Then {scratch, shift} shifts left 1; the shift register MSB enters scratch bit 0.
  - The bit leaving the top scratch digit MSB is ORed into sticky overflow.
  - Counter increments. When counter == InBits-1 on an edge, next state is FINISH.
  - Exactly InBits CONV edges.
- FINISH, single edge:
  - Output registers load: ovf=sticky.
  - bcd = sticky ? {Digits{OvfNibble}} : scratch.
  - done=1, next state IDLE.
- Latency: if start is accepted at edge E0, bcd, ovf and done are valid after edge E0+InBits+1. With defaults, done is high 28 cycles after start is sampled.
- busy is high from the cycle after acceptance through the FINISH cycle inclusive.
- start during CONV or FINISH is ignored, with no queuing.
- start in the IDLE cycle where done=1 is accepted, so back-to-back throughput is InBits+2 cycles.
- bin changing after acceptance has no effect on the running conversion.
- bcd and ovf change only at the FINISH edge; they hold otherwise, including while busy.
- Width rules:
  - Scratch register is 4*Digits bits; the shift register is InBits bits.
  - The add-3 is applied per digit in parallel and never carries between digits.
  - If InBits is small enough that overflow is impossible, ovf stays 0.

Decomposition:
- Shared header (alongside the existing auxiliary macros):
  - state encodings AUX_B2B_IDLE / CONV / FINISH (2 bits);
  - default overflow nibble constant.
- One sub-module: aux_bcd_adj3, a combinational 4-bit digit corrector (in >= 5 ? in+3 : in).
- aux_bcd_adj3 is instantiated Digits times with a generate loop.

Test Plan:
1. Zero: reset, start with bin=0 → after 28 cycles done pulses once; bcd=32'h00000000, ovf=0; busy low the following cycle.
2. Nominal: bin=12345678 → bcd=32'h12345678, ovf=0; done exactly InBits+1=28 cycles after start edge; bcd holds its old value (0) through the conversion.
3. Max in range, then overflow:
   - bin=99999999 → bcd=32'h99999999, ovf=0.
   - Then bin=100000000 → bcd=32'hEEEEEEEE, ovf=1.
   - Then bin=134217727 → ovf=1.
4. Handshake:
   - start held high continuously with bin=42 → conversions every 29 cycles, each done one cycle wide, bcd=32'h00000042.
   - A start pulse with bin=7 mid-CONV → ignored; result stays 42.
5. Reset mid-operation: start bin=555, assert rst_n low at cycle 10 → bcd=0, ovf=0, busy=0 immediately (asynchronous); no done pulse after release; a new start with bin=555 yields 32'h00000555.
6. Parameter variant: InBits=8, Digits=3, bin=255 → bcd=12'h255, done at 9 cycles, ovf never asserts across bin=0..255 sweep versus reference model.
